// File: rtl/dmem_axi_bridge.sv
// dmem_axi_bridge: turns the core's level-held data-memory request into one AXI4-Lite transaction at a time.
// Define DMEM_ERR_EN to add the access_fault output for RESP errors and timeouts.
module dmem_axi_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read_enable,
   input  logic                  write_enable,
   input  logic [31:0]           write_data,
   input  logic [3:0]            write_wstrb,
   output logic [31:0]           read_data,
   output logic                  read_valid,
   output logic                  write_ready,
`ifdef DMEM_ERR_EN
   output logic                  access_fault,
`endif
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic [2:0]            m_awprot,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [31:0]           m_wdata,
   output logic [3:0]            m_wstrb,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [2:0]            m_arprot,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [31:0]           m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready
);

   typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE} state_t;

   localparam int               CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata, r_rdata, w_rdata_nxt;
   logic [3:0]            r_wstrb;
   logic                  r_is_wr;
   logic                  r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
   logic                  w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
   logic                  r_rd_pulse, r_wr_pulse;
   logic [CNT_W-1:0]      r_cnt;
   logic                  w_timeout, w_err, w_enter_done;
   logic                  w_aw_done, w_w_done;
   logic                  w_rresp_err, w_bresp_err;

`ifdef DMEM_ERR_EN
   assign w_rresp_err = |m_rresp;
   assign w_bresp_err = |m_bresp;
`else
   assign w_rresp_err = 1'b0;
   assign w_bresp_err = 1'b0;
`endif

   // The counter is cleared on every state change, so each wait state gets its own budget.
   assign w_timeout = TO_EN && (r_cnt == CNT_LAST);
   assign w_aw_done = ~r_awvalid | m_awready;
   assign w_w_done  = ~r_wvalid | m_wready;

   always_comb begin
      w_state_nxt   = r_state;
      w_arvalid_nxt = r_arvalid;
      w_rready_nxt  = r_rready;
      w_awvalid_nxt = r_awvalid;
      w_wvalid_nxt  = r_wvalid;
      w_bready_nxt  = r_bready;
      w_rdata_nxt   = r_rdata;
      w_err         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (write_enable) begin
               w_state_nxt   = S_WR_REQ;
               w_awvalid_nxt = 1'b1;
               w_wvalid_nxt  = 1'b1;
            end else if (read_enable) begin
               w_state_nxt   = S_RD_ADDR;
               w_arvalid_nxt = 1'b1;
            end
         end
         S_RD_ADDR: begin
            if (m_arready) begin
               w_state_nxt   = S_RD_DATA;
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt   = S_DONE;
               w_arvalid_nxt = 1'b0;
               w_rdata_nxt   = '0;
               w_err         = 1'b1;
            end
         end
         S_RD_DATA: begin
            if (m_rvalid) begin
               w_state_nxt  = S_DONE;
               w_rready_nxt = 1'b0;
               w_rdata_nxt  = w_rresp_err ? 32'h0 : m_rdata;
               w_err        = w_rresp_err;
            end else if (w_timeout) begin
               w_state_nxt  = S_DONE;
               w_rready_nxt = 1'b0;
               w_rdata_nxt  = '0;
               w_err        = 1'b1;
            end
         end
         S_WR_REQ: begin
            if (m_awready) w_awvalid_nxt = 1'b0;
            if (m_wready)  w_wvalid_nxt  = 1'b0;
            if (w_aw_done && w_w_done) begin
               w_state_nxt  = S_WR_RESP;
               w_bready_nxt = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt   = S_DONE;
               w_awvalid_nxt = 1'b0;
               w_wvalid_nxt  = 1'b0;
               w_err         = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (m_bvalid) begin
               w_state_nxt  = S_DONE;
               w_bready_nxt = 1'b0;
               w_err        = w_bresp_err;
            end else if (w_timeout) begin
               w_state_nxt  = S_DONE;
               w_bready_nxt = 1'b0;
               w_err        = 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_is_wr    <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         r_rdata    <= '0;
         r_rd_pulse <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_arvalid  <= w_arvalid_nxt;
         r_rready   <= w_rready_nxt;
         r_awvalid  <= w_awvalid_nxt;
         r_wvalid   <= w_wvalid_nxt;
         r_bready   <= w_bready_nxt;
         r_rdata    <= w_rdata_nxt;
         r_rd_pulse <= w_enter_done & ~r_is_wr;
         r_wr_pulse <= w_enter_done & r_is_wr;
         // Capture once at acceptance; the core's request may glitch afterwards.
         if (r_state == S_IDLE && w_state_nxt != S_IDLE) begin
            r_addr  <= {address[ADDR_WIDTH-1:2], 2'b00};
            r_wdata <= write_data;
            r_wstrb <= write_wstrb;
            r_is_wr <= write_enable;
         end
         if (w_state_nxt != r_state)
            r_cnt <= '0;
         else if (TO_EN && (r_state inside {S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP}))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

`ifdef DMEM_ERR_EN
   logic r_fault;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_fault <= 1'b0;
      else          r_fault <= w_enter_done & w_err;
   end
   assign access_fault = r_fault;
`else
   logic w_unused_err;
   assign w_unused_err = ^{m_rresp, m_bresp, w_err, w_rresp_err, w_bresp_err};
`endif

   assign read_data   = r_rdata;
   assign read_valid  = r_rd_pulse;
   assign write_ready = r_wr_pulse;
   assign m_awaddr    = r_addr;
   assign m_araddr    = r_addr;
   assign m_awprot    = 3'b000;
   assign m_arprot    = 3'b000;
   assign m_awvalid   = r_awvalid;
   assign m_wdata     = r_wdata;
   assign m_wstrb     = r_wstrb;
   assign m_wvalid    = r_wvalid;
   assign m_bready    = r_bready;
   assign m_arvalid   = r_arvalid;
   assign m_rready    = r_rready;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Bench for dmem_axi_bridge: directed and randomized load/store transactions against a delay-driven AXI slave.
// Expected timing is derived from the slave delays and the timeout budget; build with DMEM_ERR_EN to check access_fault.
module tb_dmem_axi_bridge;

   localparam int AW = 32;
   localparam int TO = 8;
`ifdef DMEM_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset_n;
   logic [AW-1:0] address;
   logic          read_enable, write_enable;
   logic [31:0]   write_data;
   logic [3:0]    write_wstrb;
   logic [31:0]   read_data;
   logic          read_valid, write_ready;
   logic          access_fault;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic [2:0]    m_awprot, m_arprot;
   logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic          m_arvalid, m_arready, m_rvalid, m_rready;
   logic [31:0]   m_wdata, m_rdata;
   logic [3:0]    m_wstrb;
   logic [1:0]    m_bresp, m_rresp;

   always #5 clock = ~clock;

   dmem_axi_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .address(address), .read_enable(read_enable), .write_enable(write_enable),
      .write_data(write_data), .write_wstrb(write_wstrb),
      .read_data(read_data), .read_valid(read_valid), .write_ready(write_ready),
`ifdef DMEM_ERR_EN
      .access_fault(access_fault),
`endif
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

`ifndef DMEM_ERR_EN
   assign access_fault = 1'b0;
`endif

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_rvalid  = 1'b0; m_bvalid  = 1'b0;
      m_rresp   = 2'b00; m_bresp  = 2'b00;
   endtask

   // Loads use d_a = AR wait, d_b = R wait; stores use d_a = AW wait, d_b = W wait, d_c = B wait.
   // Waits of TO or more never complete inside the timeout budget.
   task automatic run_txn(input bit is_wr, input bit both_en, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd,
                          input logic [1:0] resp, input int d_a, input int d_b, input int d_c,
                          input int rst_cyc);
      int done, a_end, b_end, rdy_beg, rdy_end, t_both;
      int a_cnt, w_cnt, a_hs, w_hs;
      bit to, fault_exp, r_taken, b_taken;
      logic [31:0] new_rdata;
      logic [AW-1:0] al;

      al = addr & ~32'h3;
      to = 1'b0; rdy_beg = 1; rdy_end = 0; b_end = 0;
      if (!is_wr) begin
         if (d_a >= TO) begin
            to = 1'b1; a_end = TO; done = TO + 1;
         end else begin
            a_end = 1 + d_a; rdy_beg = a_end + 1;
            if (d_b >= TO) begin to = 1'b1; done = rdy_beg + TO; end
            else done = rdy_beg + d_b + 1;
            rdy_end = done - 1;
         end
      end else begin
         a_end = (1 + d_a < TO) ? 1 + d_a : TO;
         b_end = (1 + d_b < TO) ? 1 + d_b : TO;
         if (d_a >= TO || d_b >= TO) begin
            to = 1'b1; done = TO + 1;
         end else begin
            t_both = (d_a > d_b) ? 1 + d_a : 1 + d_b;
            rdy_beg = t_both + 1;
            if (d_c >= TO) begin to = 1'b1; done = rdy_beg + TO; end
            else done = rdy_beg + d_c + 1;
            rdy_end = done - 1;
         end
      end
      if (is_wr)                       new_rdata = exp_rdata;
      else if (to || (ERR && resp != 0)) new_rdata = 32'h0;
      else                             new_rdata = rd;
      fault_exp = to || (resp != 2'b00);

      chk("idle_arvalid", m_arvalid, 1'b0);
      chk("idle_awvalid", m_awvalid, 1'b0);
      address = addr; write_data = wd; write_wstrb = ws;
      write_enable = is_wr; read_enable = !is_wr || both_en;
      slave_idle();
      a_cnt = 0; w_cnt = 0; a_hs = 0; w_hs = 0; r_taken = 1'b0; b_taken = 1'b0;

      for (int c = 1; c <= done + 1; c++) begin
         @(negedge clock);
         chk("arvalid", m_arvalid, !is_wr && c <= a_end);
         chk("awvalid", m_awvalid, is_wr && c <= a_end);
         chk("wvalid", m_wvalid, is_wr && c <= b_end);
         chk("rready", m_rready, !is_wr && c >= rdy_beg && c <= rdy_end);
         chk("bready", m_bready, is_wr && c >= rdy_beg && c <= rdy_end);
         chk("read_valid", read_valid, !is_wr && c == done);
         chk("write_ready", write_ready, is_wr && c == done);
         chk("read_data", read_data, (c >= done) ? new_rdata : exp_rdata);
`ifdef DMEM_ERR_EN
         chk("access_fault", access_fault, (c == done) && fault_exp);
`endif
         if (c <= a_end) begin
            if (is_wr) chk("awaddr", m_awaddr, al);
            else       chk("araddr", m_araddr, al);
         end
         if (is_wr && c <= b_end) begin
            chk("wdata", m_wdata, wd);
            chk("wstrb", m_wstrb, ws);
         end

         if (c == rst_cyc) begin
            reset_n = 1'b0;
            #1;
            chk("rst_rready", m_rready, 1'b0);
            chk("rst_arvalid", m_arvalid, 1'b0);
            chk("rst_read_valid", read_valid, 1'b0);
            chk("rst_read_data", read_data, 32'h0);
            read_enable = 1'b0; write_enable = 1'b0;
            slave_idle();
            exp_rdata = 32'h0;
            @(negedge clock);
            reset_n = 1'b1;
            return;
         end

         m_arready = m_arvalid && (a_cnt == d_a);
         m_awready = m_awvalid && (a_cnt == d_a);
         m_wready  = m_wvalid && (w_cnt == d_b);
         if (m_arvalid || m_awvalid) begin
            if (a_cnt == d_a) a_hs = c;
            a_cnt++;
         end
         if (m_wvalid) begin
            if (w_cnt == d_b) w_hs = c;
            w_cnt++;
         end
         m_rvalid = 1'b0;
         if (!is_wr && a_hs > 0 && !r_taken && c >= a_hs + 1 + d_b) begin
            m_rvalid = 1'b1; m_rdata = rd; m_rresp = resp;
            if (m_rready) r_taken = 1'b1;
         end
         m_bvalid = 1'b0;
         if (is_wr && a_hs > 0 && w_hs > 0 && !b_taken &&
             c >= ((a_hs > w_hs) ? a_hs : w_hs) + 1 + d_c) begin
            m_bvalid = 1'b1; m_bresp = resp;
            if (m_bready) b_taken = 1'b1;
         end

         if (c < done) begin
            address = $urandom; write_data = $urandom; write_wstrb = 4'($urandom);
         end else begin
            read_enable = 1'b0; write_enable = 1'b0;
         end
      end
      slave_idle();
      exp_rdata = new_rdata;
   endtask

   initial begin
      bit          rw, rb;
      int          ra, rbd, rc;
      logic [1:0]  rs;

      reset_n = 1'b0;
      address = '0; read_enable = 1'b0; write_enable = 1'b0;
      write_data = '0; write_wstrb = '0; m_rdata = '0;
      slave_idle();
      repeat (3) @(negedge clock);
      chk("reset_arvalid", m_arvalid, 1'b0);
      chk("reset_awvalid", m_awvalid, 1'b0);
      chk("reset_wvalid", m_wvalid, 1'b0);
      chk("reset_rready", m_rready, 1'b0);
      chk("reset_bready", m_bready, 1'b0);
      chk("reset_read_valid", read_valid, 1'b0);
      chk("reset_write_ready", write_ready, 1'b0);
      chk("reset_read_data", read_data, 32'h0);
      chk("reset_awaddr", m_awaddr, 32'h0);
      chk("prot", {m_awprot, m_arprot}, 6'h0);
      chk("reset_access_fault", access_fault, 1'b0);
      reset_n = 1'b1;
      @(negedge clock);
      exp_rdata = 32'h0;

      // zero-wait load, unaligned address
      run_txn(1'b0, 1'b0, 32'h8000_0006, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0, 0, 0, -1);
      // store with AW accepted 3 cycles before W
      run_txn(1'b1, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b0011, 32'h0, 2'b00, 0, 3, 0, -1);
      // store with W first, same-cycle case, then write priority over read
      run_txn(1'b1, 1'b0, 32'h0000_1004, 32'h0BAD_F00D, 4'b1100, 32'h0, 2'b00, 2, 0, 1, -1);
      run_txn(1'b1, 1'b0, 32'h0000_1008, 32'h1357_9BDF, 4'b1111, 32'h0, 2'b00, 2, 2, 0, -1);
      run_txn(1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h55, 2'b00, 1, 1, 1, -1);
      // slave never answers AR
      run_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00, 100, 0, 0, -1);
      // nonzero read_data, then reset in RD_DATA, then a fresh load
      run_txn(1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1, 2, 0, -1);
      run_txn(1'b0, 1'b0, 32'h0000_0048, 32'h0, 4'h0, 32'h1111_1111, 2'b00, 0, 100, 0, 4);
      run_txn(1'b0, 1'b0, 32'h0000_004C, 32'h0, 4'h0, 32'h2222_3333, 2'b00, 0, 0, 0, -1);
      // error responses and write-side timeouts
      run_txn(1'b1, 1'b0, 32'h0000_0050, 32'h7777_8888, 4'hF, 32'h0, 2'b10, 0, 0, 0, -1);
      run_txn(1'b0, 1'b0, 32'h0000_0054, 32'h0, 4'h0, 32'h0000_0077, 2'b10, 0, 0, 0, -1);
      run_txn(1'b0, 1'b0, 32'h0000_0058, 32'h0, 4'h0, 32'h4444_5555, 2'b00, 7, 7, 0, -1);
      run_txn(1'b1, 1'b0, 32'h0000_005C, 32'h1, 4'h1, 32'h0, 2'b00, 0, 0, 9, -1);
      run_txn(1'b1, 1'b0, 32'h0000_0060, 32'h2, 4'h2, 32'h0, 2'b00, 100, 1, 0, -1);
      run_txn(1'b0, 1'b0, 32'h0000_0064, 32'h0, 4'h0, 32'h9999_AAAA, 2'b00, 0, 0, 0, -1);

      for (int i = 0; i < 40; i++) begin
         rw  = 1'($urandom_range(0, 1));
         rb  = rw && ($urandom_range(0, 3) == 0);
         ra  = ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 2) : $urandom_range(0, 4);
         rbd = ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 2) : $urandom_range(0, 4);
         rc  = ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 2) : $urandom_range(0, 4);
         rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_txn(rw, rb, $urandom, $urandom, 4'($urandom), $urandom, rs, ra, rbd, rc, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_axi_bridge.md
Name: dmem_axi_bridge

Overview:
- Downstream of the single-cycle core's data-memory port. Converts its level-held load/store request (address, read_enable, write_enable, write_data, write_wstrb) into AXI4-Lite master transactions.
- Returns completion to the core as one-cycle read_valid / write_ready pulses, which drive the core's mem_stall release.
- One outstanding transaction at a time. Request is registered at acceptance, so the core's combinational request may glitch mid-transaction without effect.

Parameters:
- ADDR_WIDTH, 32, width of core address and AXI AWADDR/ARADDR.
- TIMEOUT_CYCLES, 256, cycles to wait for AR/AW/W/R/B progress before forced completion; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_WIDTH  core byte address.
- read_enable  in  1  core load request, held until read_valid.
- write_enable  in  1  core store request, held until write_ready.
- write_data  in  32  store data, unshifted word from rs2.
- write_wstrb  in  4  byte strobes.
- read_data  out  32  load word, full aligned word (core masks it).
- read_valid  out  1  one-cycle load completion pulse.
- write_ready  out  1  one-cycle store completion pulse.
- m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_WIDTH/1/1  AXI write address.
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  AXI write data.
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI write response.
- m_araddr/m_arvalid/m_arready  out/out/in  ADDR_WIDTH/1/1  AXI read address.
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  AXI read data.
- access_fault  out  1  error pulse; present only with DMEM_ERR_EN.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: samples the request.
  - write_enable=1 → WR_REQ; write takes priority if both enables are high.
  - Else read_enable=1 → RD_ADDR.
  - Captures address with bits [1:0] forced to 0, plus write_data and write_wstrb, into internal registers.
- RD_ADDR: m_arvalid=1 until m_arready → RD_DATA.
- RD_DATA: m_rready=1; on m_rvalid, latch m_rdata into read_data → DONE.
- WR_REQ:
  - m_awvalid and m_wvalid are asserted together.
  - Each valid drops independently after its own handshake.
  - Move to WR_RESP once both handshakes complete, including the same-cycle case.
- WR_RESP: m_bready=1; on m_bvalid → DONE.
- DONE:
  - Pulse read_valid or write_ready for exactly one cycle, per the captured type.
  - Unconditionally → IDLE.
  - The request is not resampled in DONE; the core advances its pc on this edge.
- Latency: request visible in cycle 0 → AXI valid asserted in cycle 1. Zero-wait slave: load completion pulse in cycle 3, store in cycle 3 (B in cycle 2).
- read_data holds its last value until the next load completes.
- m_*prot are tied to 0; all AXI valids/readies are registered outputs.
- Timeout:
  - A counter clears on state entry and increments in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - When it reaches TIMEOUT_CYCLES (nonzero), all AXI valids drop and the FSM goes to DONE.
  - For a timed-out load, read_data=32'h0.
- Reset (asynchronous, reset_n=0, including mid-transaction):
  - State goes to IDLE.
  - All AXI valid/ready outputs, read_valid, write_ready and access_fault go to 0.
  - read_data and the captured registers go to 0.
- Sub-word accesses are unaligned within the word only by strobe; no misalignment checks are made.

Optional Feature:
- Macro: DMEM_ERR_EN.
- With DMEM_ERR_EN defined:
  - access_fault is present.
  - It pulses in the DONE cycle if the captured m_rresp or m_bresp was nonzero, or the timeout fired.
  - A failing load returns read_data=0.
- Without DMEM_ERR_EN: the port is absent, RESP values are ignored, and m_rdata is returned regardless.

Test Plan:
- Load, zero-wait slave: address=0x8000_0006, read_enable=1, rdata=0x1234_5678 → m_araddr=0x8000_0004 in cycle 1; read_valid pulses one cycle with read_data=0x1234_5678.
- Store with AW ready 3 cycles before W: write_data=0xA5A5_A5A5, wstrb=4'b0011 → m_awvalid drops after its handshake, m_wvalid held until its own; write_ready pulses once after BVALID.
- Simultaneous read_enable and write_enable → only the AW/W path is issued; no ARVALID; write_ready pulses, read_valid does not.
- Slave never responds, TIMEOUT_CYCLES=8 → forced DONE 8 cycles after entering RD_ADDR, with read_valid=1 and read_data=0 (access_fault=1 with DMEM_ERR_EN).
- reset_n low during RD_DATA → m_rready, m_arvalid and read_valid go to 0 immediately; after release, a fresh load completes normally.
- With DMEM_ERR_EN, m_bresp=2'b10 → write_ready and access_fault pulse in the same cycle.
